// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package if_fetch_pkg;

    typedef enum logic [1:0] {
        LOOKUP = 2'd0,
        FILL   = 2'd1,
        LAST   = 2'd2,
        HOLD   = 2'd3
    } fetch_state_t;

    // Hold lengths the memory stage requests for byte, half and word accesses
    localparam logic [2:0] HOLD_BYTE = 3'd3;
    localparam logic [2:0] HOLD_HALF = 3'd4;
    localparam logic [2:0] HOLD_WORD = 3'd6;

    localparam logic [31:0] BUBBLE = 32'h0000_0000;

    // Index of the highest set bit of the one-hot hold bus; 0 means no hold
    function automatic logic [2:0] stall_to_count(input logic [6:0] stall);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (stall[i]) begin
                cnt = 3'(i);
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/if_byte_assembler.sv
// rtl/if_byte_assembler.sv - collects bytes 0..2 of a missed word and packs it little-endian
module if_byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        advance,
    input  logic [7:0]  din_i,
    output logic [1:0]  idx_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx;
    logic [23:0] asm_q;

    // Each advance captures the byte requested one cycle earlier (idx - 1)
    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= 2'd0;
            asm_q <= 24'd0;
        end else if (start) begin
            idx <= 2'd1;
        end else if (advance) begin
            case (idx)
                2'd1:    asm_q[7:0]   <= din_i;
                2'd2:    asm_q[15:8]  <= din_i;
                2'd3:    asm_q[23:16] <= din_i;
                default: asm_q        <= asm_q;
            endcase
            idx <= idx + 2'd1;
        end
    end

    assign idx_o  = idx;
    assign word_o = {din_i, asm_q};

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - RV32I fetch stage: icache lookup, byte-wise miss fill, decode redirects and holds
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    input  logic        next_ignore_i,
    input  logic [6:0]  stall_i,
    output logic [31:0] ic_addr_o,
    input  logic        ic_hit_i,
    input  logic [31:0] ic_inst_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_rd_o,
    input  logic [7:0]  mem_din_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        ignore_o
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  pc_o_n, inst_n;
    logic         ignore_n;
    logic [2:0]   hold_cnt, hold_cnt_n;
    logic [2:0]   hold_req;
    logic         rd, asm_start, asm_advance;
    logic [31:0]  rd_addr;
    logic [1:0]   idx;
    logic [31:0]  asm_word;

    if_byte_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .start   (asm_start),
        .advance (asm_advance),
        .din_i   (mem_din_i),
        .idx_o   (idx),
        .word_o  (asm_word)
    );

    assign hold_req  = stall_to_count(stall_i);
    assign ic_addr_o = pc;

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        pc_o_n      = pc_o;
        inst_n      = inst_o;
        ignore_n    = 1'b0;
        hold_cnt_n  = hold_cnt;
        rd          = 1'b0;
        rd_addr     = pc;
        asm_start   = 1'b0;
        asm_advance = 1'b0;
        case (state)
            LOOKUP: begin
                if (jump_i) begin
                    pc_n     = jump_addr_i;
                    inst_n   = BUBBLE;
                    ignore_n = 1'b1;
                end else if (next_ignore_i) begin
                    pc_n     = pc_o;
                    inst_n   = BUBBLE;
                    ignore_n = 1'b1;
                end else if (hold_req != 3'd0) begin
                    inst_n = BUBBLE;
                end else if (ic_hit_i) begin
                    inst_n = ic_inst_i;
                    pc_o_n = pc + 32'd4;
                    pc_n   = pc + 32'd4;
                end else begin
                    rd        = 1'b1;
                    asm_start = 1'b1;
                    inst_n    = BUBBLE;
                    state_n   = FILL;
                end
                // A hold overrides whatever this lookup would have started
                if (hold_req != 3'd0) begin
                    hold_cnt_n = hold_req;
                    state_n    = HOLD;
                end
            end
            FILL: begin
                rd          = 1'b1;
                rd_addr     = pc + {30'd0, idx};
                asm_advance = 1'b1;
                inst_n      = BUBBLE;
                if (idx == 2'd3) begin
                    state_n = LAST;
                end
            end
            LAST: begin
                inst_n  = asm_word;
                pc_o_n  = pc + 32'd4;
                pc_n    = pc + 32'd4;
                state_n = LOOKUP;
            end
            HOLD: begin
                inst_n = BUBBLE;
                if (hold_cnt <= 3'd1) begin
                    hold_cnt_n = 3'd0;
                    state_n    = LOOKUP;
                end else begin
                    hold_cnt_n = hold_cnt - 3'd1;
                end
            end
            default: state_n = LOOKUP;
        endcase
    end

    assign mem_rd_o   = rd & ~rst;
    assign mem_addr_o = mem_rd_o ? rd_addr : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOOKUP;
            pc       <= RESET_PC;
            pc_o     <= 32'd0;
            inst_o   <= BUBBLE;
            ignore_o <= 1'b0;
            hold_cnt <= 3'd0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            pc_o     <= pc_o_n;
            inst_o   <= inst_n;
            ignore_o <= ignore_n;
            hold_cnt <= hold_cnt_n;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - scoreboard bench for if_fetch
module tb_if_fetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ign;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        next_ignore_i;
    logic [6:0]  stall_i;
    logic [31:0] ic_addr_o;
    logic        ic_hit_i;
    logic [31:0] ic_inst_i;
    logic [31:0] mem_addr_o;
    logic        mem_rd_o;
    logic [7:0]  mem_din_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        ignore_o;

    logic [7:0]  mem [0:255];
    logic        hit_en;
    exp_t        sb[$];
    exp_t        e;
    int          vectors = 0;
    int          miscompares = 0;

    if_fetch #(.RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_i        (jump_i),
        .jump_addr_i   (jump_addr_i),
        .next_ignore_i (next_ignore_i),
        .stall_i       (stall_i),
        .ic_addr_o     (ic_addr_o),
        .ic_hit_i      (ic_hit_i),
        .ic_inst_i     (ic_inst_i),
        .mem_addr_o    (mem_addr_o),
        .mem_rd_o      (mem_rd_o),
        .mem_din_i     (mem_din_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .ignore_o      (ignore_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        ic_hit_i  = hit_en && !(ic_addr_o inside {32'h10, 32'h14, 32'h24});
        ic_inst_i = ic_hit_i ? (32'hC0DE_0000 | {16'd0, ic_addr_o[15:0]}) : 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        if (mem_rd_o) mem_din_i <= mem[mem_addr_o[7:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({pc_o, inst_o, ignore_o, mem_rd_o} !== {32'h0, 32'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: pc_o=%h inst_o=%h ignore_o=%b mem_rd_o=%b, want 0/0/0/0",
                     pc_o, inst_o, ignore_o, mem_rd_o);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (ic_addr_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_ic_addr: got %h want 00000000", ic_addr_o);
        end
    endtask

    task automatic test_hits();
        hit_en = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{pc: 32'(4 * (i + 1)), inst: 32'hC0DE_0000 | 32'(4 * i), ign: 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            e = sb.pop_front();
            vectors++;
            if ({pc_o, inst_o, ignore_o} !== {e.pc, e.inst, e.ign}) begin
                miscompares++;
                $display("FAIL hit_%0d: got pc_o=%h inst_o=%h ign=%b want %h %h %b",
                         i, pc_o, inst_o, ignore_o, e.pc, e.inst, e.ign);
            end
        end
    endtask

    task automatic test_miss();
        vectors++;
        if (mem_rd_o !== 1'b1 || mem_addr_o !== 32'h10) begin
            miscompares++;
            $display("FAIL miss_read0: mem_rd_o=%b addr=%h want 1 00000010", mem_rd_o, mem_addr_o);
        end
        for (int i = 0; i < 4; i++) sb.push_back('{pc: 32'h10, inst: 32'h0, ign: 1'b0});
        sb.push_back('{pc: 32'h14, inst: 32'h0010_0513, ign: 1'b0});
        for (int i = 1; i <= 5; i++) begin
            tick();
            e = sb.pop_front();
            vectors++;
            if ({pc_o, inst_o, ignore_o} !== {e.pc, e.inst, e.ign}) begin
                miscompares++;
                $display("FAIL miss_out_%0d: got pc_o=%h inst_o=%h ign=%b want %h %h %b",
                         i, pc_o, inst_o, ignore_o, e.pc, e.inst, e.ign);
            end
            if (i <= 3) begin
                vectors++;
                if (mem_rd_o !== 1'b1 || mem_addr_o !== 32'(32'h10 + i)) begin
                    miscompares++;
                    $display("FAIL miss_read%0d: mem_rd_o=%b addr=%h want 1 %h",
                             i, mem_rd_o, mem_addr_o, 32'(32'h10 + i));
                end
            end else if (i == 4) begin
                vectors++;
                if (mem_rd_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL miss_read_end: mem_rd_o=%b want 0", mem_rd_o);
                end
            end
        end
    endtask

    task automatic test_jump();
        jump_i      = 1'b1;
        jump_addr_i = 32'h100;
        #1;
        vectors++;
        if (mem_rd_o !== 1'b0) begin
            miscompares++;
            $display("FAIL jump_no_read: mem_rd_o=%b want 0", mem_rd_o);
        end
        sb.push_back('{pc: 32'h14, inst: 32'h0, ign: 1'b1});
        tick();
        jump_i = 1'b0;
        e = sb.pop_front();
        vectors++;
        if ({pc_o, inst_o, ignore_o, ic_addr_o} !== {e.pc, e.inst, e.ign, 32'h100}) begin
            miscompares++;
            $display("FAIL jump_bubble: got pc_o=%h inst_o=%h ign=%b ic_addr=%h want %h %h %b 00000100",
                     pc_o, inst_o, ignore_o, ic_addr_o, e.pc, e.inst, e.ign);
        end
        sb.push_back('{pc: 32'h104, inst: 32'hC0DE_0100, ign: 1'b0});
        tick();
        e = sb.pop_front();
        vectors++;
        if ({pc_o, inst_o, ignore_o} !== {e.pc, e.inst, e.ign}) begin
            miscompares++;
            $display("FAIL jump_target: got pc_o=%h inst_o=%h ign=%b want %h %h %b",
                     pc_o, inst_o, ignore_o, e.pc, e.inst, e.ign);
        end
        jump_i      = 1'b1;
        jump_addr_i = 32'h20;
        sb.push_back('{pc: 32'h104, inst: 32'h0, ign: 1'b1});
        sb.push_back('{pc: 32'h24, inst: 32'hC0DE_0020, ign: 1'b0});
        for (int i = 0; i < 2; i++) begin
            tick();
            jump_i = 1'b0;
            e = sb.pop_front();
            vectors++;
            if ({pc_o, inst_o, ignore_o} !== {e.pc, e.inst, e.ign}) begin
                miscompares++;
                $display("FAIL jump2_%0d: got pc_o=%h inst_o=%h ign=%b want %h %h %b",
                         i, pc_o, inst_o, ignore_o, e.pc, e.inst, e.ign);
            end
        end
    endtask

    task automatic test_ignore_hold();
        next_ignore_i = 1'b1;
        stall_i       = 7'b100_0000;
        #1;
        vectors++;
        if (mem_rd_o !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_no_read: mem_rd_o=%b want 0", mem_rd_o);
        end
        sb.push_back('{pc: 32'h24, inst: 32'h0, ign: 1'b1});
        for (int i = 0; i < 6; i++) sb.push_back('{pc: 32'h24, inst: 32'h0, ign: 1'b0});
        for (int i = 1; i <= 7; i++) begin
            tick();
            next_ignore_i = 1'b0;
            stall_i       = 7'd0;
            #1;
            e = sb.pop_front();
            vectors++;
            if ({pc_o, inst_o, ignore_o} !== {e.pc, e.inst, e.ign}) begin
                miscompares++;
                $display("FAIL hold_out_%0d: got pc_o=%h inst_o=%h ign=%b want %h %h %b",
                         i, pc_o, inst_o, ignore_o, e.pc, e.inst, e.ign);
            end
            vectors++;
            if (i <= 6) begin
                if (mem_rd_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hold_read_%0d: mem_rd_o=%b want 0", i, mem_rd_o);
                end
            end else if ({ic_addr_o, mem_rd_o, mem_addr_o} !== {32'h24, 1'b1, 32'h24}) begin
                miscompares++;
                $display("FAIL hold_release: ic_addr=%h mem_rd_o=%b addr=%h want 00000024 1 00000024",
                         ic_addr_o, mem_rd_o, mem_addr_o);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        tick();
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (mem_rd_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_drops_read: mem_rd_o=%b want 0", mem_rd_o);
        end
        tick();
        vectors++;
        if ({pc_o, inst_o, ignore_o} !== {32'h0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_mid_fill: pc_o=%h inst_o=%h ign=%b want 0/0/0", pc_o, inst_o, ignore_o);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (ic_addr_o !== 32'h0 || mem_rd_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_restart_addr: ic_addr=%h mem_rd_o=%b want 00000000 0", ic_addr_o, mem_rd_o);
        end
        sb.push_back('{pc: 32'h4, inst: 32'hC0DE_0000, ign: 1'b0});
        tick();
        e = sb.pop_front();
        vectors++;
        if ({pc_o, inst_o, ignore_o} !== {e.pc, e.inst, e.ign}) begin
            miscompares++;
            $display("FAIL rst_first_hit: got pc_o=%h inst_o=%h ign=%b want %h %h %b",
                     pc_o, inst_o, ignore_o, e.pc, e.inst, e.ign);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[8'h10] = 8'h13;
        mem[8'h11] = 8'h05;
        mem[8'h12] = 8'h10;
        mem[8'h13] = 8'h00;
        rst           = 1'b1;
        jump_i        = 1'b0;
        jump_addr_i   = 32'h0;
        next_ignore_i = 1'b0;
        stall_i       = 7'd0;
        hit_en        = 1'b0;
        mem_din_i     = 8'h0;
        test_reset();
        test_hits();
        test_miss();
        test_jump();
        test_ignore_hold();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
